// File: rtl/iterative_karatsuba_param_if.sv
// Request/complete bus of the parametrised iterative Karatsuba multiplier.
// signed_mode exists only when KARATSUBA_SIGNED_EN is defined.
interface iterative_karatsuba_param_if #(parameter int N = 32);
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] c;
`ifdef KARATSUBA_SIGNED_EN
   logic           signed_mode;
`endif

   modport master (
      output start, a, b,
      input  busy, done, c
`ifdef KARATSUBA_SIGNED_EN
      , output signed_mode
`endif
   );

   modport slave (
      input  start, a, b,
      output busy, done, c
`ifdef KARATSUBA_SIGNED_EN
      , input signed_mode
`endif
   );
endinterface

// File: rtl/iterative_karatsuba_param.sv
// N x N -> 2N multiplier: one shared H x H multiplier over HI/LO/MID cycles, then COMB.
// Optional two's-complement operands with KARATSUBA_SIGNED_EN.
module iterative_karatsuba_param #(
   parameter int N = 32
) (
   input logic                        clk,
   input logic                        rst,
   iterative_karatsuba_param_if.slave bus
);
   localparam int H = N / 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0, HI = 3'd1, LO = 3'd2, MID = 3'd3, COMB = 3'd4, DONE = 3'd5
   } state_t;

   state_t         state_r, state_nxt_s;
   logic           accept_s;
   logic           busy_nxt_s;
   logic [N-1:0]   a_r, b_r, a_cap_s, b_cap_s;
   logic [N-1:0]   z2_r, z0_r, prod_s;
   logic [N:0]     z1_r, z1_s;
   logic [2*N-1:0] c_r, comb_s, res_s;
   logic           busy_r, done_r;
   logic [H-1:0]   ah_s, al_s, bh_s, bl_s, dx_s, dy_s, mx_s, my_s;
   logic           sgn_s;
`ifdef KARATSUBA_SIGNED_EN
   logic           neg_r, neg_cap_s;
`endif

   // next-state logic; start only matters in IDLE and DONE
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               accept_s    = 1'b1;
               state_nxt_s = HI;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         HI:   state_nxt_s = LO;
         LO:   state_nxt_s = MID;
         MID:  state_nxt_s = COMB;
         COMB: state_nxt_s = DONE;
         DONE: begin
            if (bus.start) begin
               accept_s    = 1'b1;
               state_nxt_s = HI;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
      busy_nxt_s = (state_nxt_s == HI) || (state_nxt_s == LO) ||
                   (state_nxt_s == MID) || (state_nxt_s == COMB);
   end

   // operand capture; signed operands are reduced to magnitudes up front
   always_comb begin
      a_cap_s = bus.a;
      b_cap_s = bus.b;
`ifdef KARATSUBA_SIGNED_EN
      neg_cap_s = bus.signed_mode & (bus.a[N-1] ^ bus.b[N-1]);
      if (bus.signed_mode && bus.a[N-1]) begin
         a_cap_s = ~bus.a + {{(N-1){1'b0}}, 1'b1};
      end else begin
         a_cap_s = bus.a;
      end
      if (bus.signed_mode && bus.b[N-1]) begin
         b_cap_s = ~bus.b + {{(N-1){1'b0}}, 1'b1};
      end else begin
         b_cap_s = bus.b;
      end
`endif
   end

   // shared multiplier: operand select depends on state only
   always_comb begin
      ah_s = a_r[N-1:H];
      al_s = a_r[H-1:0];
      bh_s = b_r[N-1:H];
      bl_s = b_r[H-1:0];
      if (al_s < ah_s) begin
         dx_s = ah_s - al_s;
      end else begin
         dx_s = al_s - ah_s;
      end
      if (bl_s < bh_s) begin
         dy_s = bh_s - bl_s;
      end else begin
         dy_s = bl_s - bh_s;
      end
      sgn_s = (al_s < ah_s) ^ (bl_s < bh_s);
      case (state_r)
         HI:      begin mx_s = ah_s;     my_s = bh_s;     end
         LO:      begin mx_s = al_s;     my_s = bl_s;     end
         MID:     begin mx_s = dx_s;     my_s = dy_s;     end
         default: begin mx_s = {H{1'b0}}; my_s = {H{1'b0}}; end
      endcase
      prod_s = {{H{1'b0}}, mx_s} * {{H{1'b0}}, my_s};
   end

   // middle term and final recombination (2N-bit sum equals the truncated 2N+1-bit sum)
   always_comb begin
      if (sgn_s) begin
         z1_s = {1'b0, z2_r} + {1'b0, z0_r} + {1'b0, prod_s};
      end else begin
         z1_s = {1'b0, z2_r} + {1'b0, z0_r} - {1'b0, prod_s};
      end
      comb_s = {z2_r, {N{1'b0}}} + {{(H-1){1'b0}}, z1_r, {H{1'b0}}} + {{N{1'b0}}, z0_r};
      res_s  = comb_s;
`ifdef KARATSUBA_SIGNED_EN
      if (neg_r) begin
         res_s = ~comb_s + {{(2*N-1){1'b0}}, 1'b1};
      end else begin
         res_s = comb_s;
      end
`endif
   end

   // state, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         a_r     <= {N{1'b0}};
         b_r     <= {N{1'b0}};
         z2_r    <= {N{1'b0}};
         z0_r    <= {N{1'b0}};
         z1_r    <= {(N+1){1'b0}};
         c_r     <= {(2*N){1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef KARATSUBA_SIGNED_EN
         neg_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= (state_nxt_s == DONE);
         if (accept_s) begin
            a_r   <= a_cap_s;
            b_r   <= b_cap_s;
`ifdef KARATSUBA_SIGNED_EN
            neg_r <= neg_cap_s;
`endif
         end
         case (state_r)
            HI:      z2_r <= prod_s;
            LO:      z0_r <= prod_s;
            MID:     z1_r <= z1_s;
            COMB:    c_r  <= res_s;
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.c    = c_r;
endmodule

// File: tb/tb_iterative_karatsuba_param.sv
// Self-checking bench for iterative_karatsuba_param: directed cases plus random products
// against a plain-arithmetic model; covers KARATSUBA_SIGNED_EN when defined.
module tb_iterative_karatsuba_param;
   localparam int N = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   iterative_karatsuba_param_if #(.N(N)) bus ();
   iterative_karatsuba_param #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic sm);
      logic [2*N-1:0] xe, ye;
      xe = {{N{1'b0}}, x};
      ye = {{N{1'b0}}, y};
      if (sm) begin
         xe = {{N{x[N-1]}}, x};
         ye = {{N{y[N-1]}}, y};
      end
      return xe * ye;
   endfunction

   task automatic chk(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input logic sm);
`ifdef KARATSUBA_SIGNED_EN
      bus.signed_mode = sm;
`endif
   endtask

   // one product; called right after an edge while the DUT is in IDLE or DONE
   task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic sm, input logic poke);
      logic [2*N-1:0] exp;
      int   cyc;
      logic busy_bad;
      exp = ref_mul(x, y, sm);
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      set_mode(sm);
      tick();
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      set_mode(1'($urandom_range(1, 0)));
      cyc      = 1;
      busy_bad = 1'b0;
      while (bus.done !== 1'b1 && cyc < 20) begin
         if (bus.busy !== 1'b1) busy_bad = 1'b1;
         bus.start = poke && (cyc == 2);
         tick();
         cyc++;
      end
      bus.start = 1'b0;
      chk({tag, "_latency"}, 64'(cyc), 64'd5);
      chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
      chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      chk({tag, "_c"}, bus.c, exp);
   endtask

   // leave DONE with start low: no further done, c held
   task automatic idle_chk(input string tag, input logic [2*N-1:0] expc);
      bus.start = 1'b0;
      tick();
      chk({tag, "_idle_done"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
      tick();
      chk({tag, "_idle_done2"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle_c"}, bus.c, expc);
   endtask

   initial begin
      logic seen_done;
      logic sm;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      set_mode(1'b0);
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_c", bus.c, 64'd0);
      rst = 1'b0;
      tick();

      run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("ones_const", bus.c, 64'hFFFF_FFFE_0000_0001);
      idle_chk("ones", 64'hFFFF_FFFE_0000_0001);

      run_op("s1", 32'h0001_FFFF, 32'h0002_0001, 1'b0, 1'b0);
      chk("s1_const", bus.c, 64'h0000_0003_FFFF_FFFF);
      run_op("dxdy1", 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
      chk("dxdy1_const", bus.c, 64'h0000_0001_0000_0000);
      run_op("b2b_zero", 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1);
      idle_chk("b2b_zero", 64'd0);

      // abort in MID
      bus.start = 1'b1;
      bus.a     = 32'hDEAD_BEEF;
      bus.b     = 32'hCAFE_F00D;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_c", bus.c, 64'd0);
      seen_done = 1'b0;
      repeat (7) begin
         tick();
         if (bus.done === 1'b1) seen_done = 1'b1;
      end
      chk("abort_no_done", 64'(seen_done), 64'd0);
      run_op("after_abort", 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);

`ifdef KARATSUBA_SIGNED_EN
      run_op("sg_m1x2", 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
      chk("sg_m1x2_const", bus.c, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("sg_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
      chk("sg_min_const", bus.c, 64'h4000_0000_0000_0000);
      run_op("us_min", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      chk("us_min_const", bus.c, 64'h4000_0000_0000_0000);
      run_op("us_m1x2", 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
      chk("us_m1x2_const", bus.c, 64'h0000_0001_FFFF_FFFE);
      run_op("sg_negpos", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
`endif

      for (int i = 0; i < 10000; i++) begin
         sm = 1'b0;
`ifdef KARATSUBA_SIGNED_EN
         sm = 1'($urandom_range(1, 0));
`endif
         run_op("rnd", $urandom, $urandom, sm, 1'($urandom_range(1, 0)));
         if (bad > 20) break;
      end
      idle_chk("final", bus.c);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/iterative_karatsuba_param.md
Name: iterative_karatsuba_param

Overview:
- Parametrised, handshaked successor to the team's fixed 32x32 iterative Karatsuba multiplier.
- Computes the exact 2N-bit product of two N-bit operands using one shared (N/2)x(N/2) multiplier over three sequential partial-product cycles.
- Adds a start/busy/done handshake, internal operand capture and back-to-back operation.
- Sits as a multi-cycle arithmetic unit behind a simple request/complete interface.

Parameters:
- N, 32, operand width. Must be even and at least 4. H = N/2 is derived internally, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE or DONE.
- a  input  N  multiplicand. Captured on the accepting edge.
- b  input  N  multiplier. Captured on the accepting edge.
- busy  output  1  high in HI, LO, MID and COMB.
- done  output  1  one-cycle pulse in DONE.
- c  output  2N  product register. Updated only at the end of COMB; held otherwise.

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - state=IDLE, busy=0, done=0, c=0, internal operand, partial and accumulator registers all 0.
  - Asserting rst during any state aborts the operation: no done pulse, c returns to 0.
- States: IDLE, HI, LO, MID, COMB, DONE.
  - IDLE: start=1 captures a and b, next state HI. start=0 stays in IDLE.
  - HI: z2 = ah*bh, stored. Next LO.
  - LO: z0 = al*bl, stored. Next MID.
  - MID:
    - dx = |al-ah|, dy = |bl-bh|, each H bits.
    - s = (al<ah) XOR (bl<bh).
    - p = dx*dy, 2H bits.
    - z1 = z2 + z0 - p if s=0; z1 = z2 + z0 + p if s=1.
    - z1 is held in an (N+1)-bit register and never overflows.
    - Next COMB.
  - COMB: c <= (z2<<N) + (z1<<H) + z0, evaluated in 2N+1 bits and truncated to 2N. The result is exact. Next DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 captures new operands, next HI (back-to-back operation).
    - start=0, next IDLE.
- Latency and throughput:
  - Accepting edge at cycle 0. done is high in cycle 5, with c valid from that cycle.
  - Back-to-back throughput: one product per 5 cycles.
- start in HI, LO, MID or COMB is ignored. a and b may change freely after the accepting edge.
- Exactly one multiplier instance of H x H width. The operand mux select is driven from state only.
- dx=0 or dy=0: the sign s is irrelevant and the result must still be exact.
- c holds its last value until the next COMB or until rst.

Optional Feature:
- Macro: KARATSUBA_SIGNED_EN.
- Defined:
  - Adds port signed_mode (input, 1), captured with a and b.
  - signed_mode=1: a and b are treated as two's complement.
  - The core operates on magnitudes |a| and |b|. |-2^(N-1)| = 2^(N-1) fits in N unsigned bits.
  - The result is negated in COMB when sign(a) XOR sign(b).
  - c is a two's-complement 2N-bit result. Latency is unchanged.
  - signed_mode=0: behaviour is identical to the unsigned block.
- Undefined: the port is absent and the block is unsigned only.

Test Plan (N=32):
- Reset, then start with a=0xFFFFFFFF, b=0xFFFFFFFF -> done pulses in cycle 5, c=0xFFFFFFFE00000001, busy high in cycles 1-4.
- a=0x0001FFFF, b=0x00020001 (exercises s=1) -> c=0x00000003FFFFFFFF. Then a=0x00010000, b=0x00010000 (dx=dy=1, s=0) -> c=0x0000000100000000.
- Back-to-back: start held high in DONE with a=0, b=0x12345678 -> next done 5 cycles later with c=0. start pulsed during busy is ignored, with no extra done.
- Reset mid-op: rst asserted in MID -> the next cycle shows IDLE, busy=0, c=0, and no done pulse. A following start completes normally.
- With KARATSUBA_SIGNED_EN, signed_mode=1:
  - a=0xFFFFFFFF, b=0x00000002 -> c=0xFFFFFFFFFFFFFFFE.
  - a=b=0x80000000 -> c=0x4000000000000000.
  - Same operands with signed_mode=0 -> c=0x4000000000000000 and 0x00000001FFFFFFFE.
- Random unsigned (and signed if enabled) operands, 10k products -> c matches the reference product every time, with done exactly 5 cycles after each accepting edge.
